// File: rtl/bit_rev_reorder_pkg.sv
// Shared defaults and helpers for the bit-reversal reorder block.
// Holds frame geometry defaults and the index mirror function.
package bit_rev_reorder_pkg;

  localparam int N_DEF     = 128;
  localparam int BITS_DEF  = 7;
  localparam int WIDTH_DEF = 16;
  localparam int MAX_BITS  = 16;

  typedef logic [MAX_BITS-1:0] idx_t;

  // Mirrors the low 'bits' bits of v; upper bits of the result are 0.
  function automatic idx_t bitrev(
    input idx_t v,
    input int   bits
  );
    idx_t r;
    idx_t s;
    r = '0;
    s = v;
    for (int j = 0; j < MAX_BITS; j++) begin
      if (j < bits) begin
        r = {r[MAX_BITS-2:0], s[0]};
        s = s >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bit_rev_reorder_bank.sv
// One ping-pong bank: simple dual-port RAM, one write port and
// one synchronous read port; contents are never reset.
module bit_rev_bank #(
  parameter int DEPTH = 128,
  parameter int AW    = 7,
  parameter int DW    = 32
) (
  input  logic          clock,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_q;

  always_ff @(posedge clock) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (i_re) begin
      r_q <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/bit_rev_reorder.sv
// Natural-order in, bit-reversed-order out frame reorder buffer
// built from two ping-pong banks.
module bit_rev_reorder
  import bit_rev_reorder_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int BITS  = BITS_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             di_en,
  input  logic [WIDTH-1:0] di_re,
  input  logic [WIDTH-1:0] di_im,
  output logic             do_en,
  output logic [WIDTH-1:0] do_re,
  output logic [WIDTH-1:0] do_im
);

  localparam int DW = 2 * WIDTH;
  localparam logic [BITS-1:0] LAST = BITS'(N - 1);

  logic [BITS-1:0] r_wr_cnt;
  logic [BITS-1:0] r_rd_cnt;
  logic            r_wr_bank;
  logic            r_rd_bank;
  logic            r_rd_act;
  logic            r_vld;
  logic            r_sel;

  logic            w_last;
  logic            w_issue;
  logic            w_rd_bank;
  logic [BITS-1:0] w_rd_idx;
  logic [BITS-1:0] w_raddr;
  logic [DW-1:0]   w_wdata;
  logic [DW-1:0]   w_q0;
  logic [DW-1:0]   w_q1;
  logic [DW-1:0]   w_q;

  // The first read is issued on the same edge that writes sample N-1,
  // so output 0 can be registered one edge later.
  assign w_last    = di_en && (r_wr_cnt == LAST);
  assign w_issue   = w_last || r_rd_act;
  assign w_rd_bank = w_last ? r_wr_bank : r_rd_bank;
  assign w_rd_idx  = w_last ? '0 : r_rd_cnt;
  assign w_raddr   = BITS'(bitrev(MAX_BITS'(w_rd_idx), BITS));
  assign w_wdata   = {di_re, di_im};
  assign w_q       = r_sel ? w_q1 : w_q0;

  bit_rev_bank #(
    .DEPTH (N),
    .AW    (BITS),
    .DW    (DW)
  ) u_bank0 (
    .clock   (clock),
    .i_we    (di_en && !r_wr_bank),
    .i_waddr (r_wr_cnt),
    .i_wdata (w_wdata),
    .i_re    (w_issue && !w_rd_bank),
    .i_raddr (w_raddr),
    .o_rdata (w_q0)
  );

  bit_rev_bank #(
    .DEPTH (N),
    .AW    (BITS),
    .DW    (DW)
  ) u_bank1 (
    .clock   (clock),
    .i_we    (di_en && r_wr_bank),
    .i_waddr (r_wr_cnt),
    .i_wdata (w_wdata),
    .i_re    (w_issue && w_rd_bank),
    .i_raddr (w_raddr),
    .o_rdata (w_q1)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_cnt  <= '0;
      r_wr_bank <= 1'b0;
    end else if (di_en) begin
      r_wr_cnt <= r_wr_cnt + 1'b1;
      if (w_last) begin
        r_wr_bank <= ~r_wr_bank;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rd_act  <= 1'b0;
      r_rd_cnt  <= '0;
      r_rd_bank <= 1'b0;
    end else if (w_last) begin
      r_rd_act  <= 1'b1;
      r_rd_cnt  <= BITS'(1);
      r_rd_bank <= r_wr_bank;
    end else if (r_rd_act) begin
      r_rd_cnt <= r_rd_cnt + 1'b1;
      if (r_rd_cnt == LAST) begin
        r_rd_act <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_vld <= 1'b0;
      r_sel <= 1'b0;
      do_en <= 1'b0;
      do_re <= '0;
      do_im <= '0;
    end else begin
      r_vld <= w_issue;
      r_sel <= w_rd_bank;
      do_en <= r_vld;
      if (r_vld) begin
        do_re <= w_q[DW-1:WIDTH];
        do_im <= w_q[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_bit_rev_reorder.sv
// Self-checking bench for bit_rev_reorder with a frame-level model.
module tb_bit_rev_reorder;

  localparam int N    = 128;
  localparam int BITS = 7;
  localparam int W    = 16;
  localparam int LOGN = 8192;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         di_en = 1'b0;
  logic [W-1:0] di_re = '0;
  logic [W-1:0] di_im = '0;
  logic         do_en;
  logic [W-1:0] do_re;
  logic [W-1:0] do_im;

  int checks   = 0;
  int failures = 0;
  int e        = 0;

  logic         log_en [LOGN];
  logic [W-1:0] log_re [LOGN];
  logic [W-1:0] log_im [LOGN];
  logic [W-1:0] f_re   [2][N];
  logic [W-1:0] f_im   [2][N];

  bit_rev_reorder #(
    .N     (N),
    .BITS  (BITS),
    .WIDTH (W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .di_en (di_en),
    .di_re (di_re),
    .di_im (di_im),
    .do_en (do_en),
    .do_re (do_re),
    .do_im (do_im)
  );

  always #5 clock = ~clock;

  always @(posedge clock) e <= e + 1;

  // log[i] holds the outputs as they stand after rising edge i
  always @(negedge clock) begin
    if (e < LOGN) begin
      log_en[e] <= do_en;
      log_re[e] <= do_re;
      log_im[e] <= do_im;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  function automatic int brev(input int k);
    int r;
    r = 0;
    for (int j = 0; j < BITS; j++) begin
      r = r * 2 + ((k >> j) & 1);
    end
    return r;
  endfunction

  task automatic step(input logic en, input logic [W-1:0] re,
                      input logic [W-1:0] im);
    di_en = en;
    di_re = re;
    di_im = im;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, W'($urandom), W'($urandom));
    end
  endtask

  task automatic fill_ramp(input int f, input int b_re, input int t_im);
    for (int i = 0; i < N; i++) begin
      f_re[f][i] = W'(b_re + i);
      f_im[f][i] = W'(t_im - i);
    end
  endtask

  task automatic fill_rand(input int f);
    for (int i = 0; i < N; i++) begin
      f_re[f][i] = W'($urandom);
      f_im[f][i] = W'($urandom);
    end
  endtask

  task automatic send(input int f, input bit toggle, output int last);
    for (int i = 0; i < N; i++) begin
      if (toggle && i > 0) begin
        step(1'b0, W'($urandom), W'($urandom));
      end
      step(1'b1, f_re[f][i], f_im[f][i]);
    end
    last = e;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, W'($urandom), W'($urandom));
      checks++;
      if (do_en !== 1'b0 || do_re !== '0 || do_im !== '0) begin
        failures++;
        $display("FAIL reset_out got en=%b re=%0d im=%0d want 0 0 0",
                 do_en, do_re, do_im);
      end
    end
    reset = 1'b1;
    idle(3);
    checks++;
    if (do_en !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_en got %b want 0", do_en);
    end
  endtask

  task automatic test_single();
    int last;
    int ke [4];
    int kr [4];
    int ki [4];
    ke = '{0, 1, 2, 127};
    kr = '{0, 64, 32, 127};
    ki = '{127, 63, 95, 0};
    fill_ramp(0, 0, 127);
    send(0, 1'b0, last);
    idle(N + 4);
    checks++;
    if (log_en[last] !== 1'b0) begin
      failures++;
      $display("FAIL single_early got en=%b want 0", log_en[last]);
    end
    for (int k = 0; k < N; k++) begin
      int idx = last + 1 + k;
      int s = brev(k);
      checks++;
      if (log_en[idx] !== 1'b1 || log_re[idx] !== f_re[0][s] ||
          log_im[idx] !== f_im[0][s]) begin
        failures++;
        $display("FAIL single k=%0d got %b %0d %0d want 1 %0d %0d", k,
                 log_en[idx], log_re[idx], log_im[idx], f_re[0][s], f_im[0][s]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      int idx = last + 1 + ke[i];
      checks++;
      if (log_re[idx] !== W'(kr[i]) || log_im[idx] !== W'(ki[i])) begin
        failures++;
        $display("FAIL single_fixed k=%0d got %0d %0d want %0d %0d", ke[i],
                 log_re[idx], log_im[idx], kr[i], ki[i]);
      end
    end
    checks++;
    if (log_en[last + 1 + N] !== 1'b0 || log_re[last + 1 + N] !== 16'd127 ||
        log_im[last + 1 + N] !== 16'd0) begin
      failures++;
      $display("FAIL single_hold got %b %0d %0d want 0 127 0",
               log_en[last + 1 + N], log_re[last + 1 + N], log_im[last + 1 + N]);
    end
  endtask

  task automatic test_gap_frames();
    int l0;
    int l1;
    int cnt;
    fill_ramp(0, 0, 127);
    fill_ramp(1, 128, 255);
    send(0, 1'b0, l0);
    idle(1);
    send(1, 1'b0, l1);
    idle(N + 4);
    cnt = 0;
    for (int i = l0 - N; i <= e; i++) begin
      if (log_en[i] === 1'b1) cnt++;
    end
    checks++;
    if (cnt != 2 * N) begin
      failures++;
      $display("FAIL gap_count got %0d want %0d", cnt, 2 * N);
    end
    checks++;
    if (log_re[l1 + 2] !== 16'd192 || log_im[l1 + 2] !== 16'd191) begin
      failures++;
      $display("FAIL gap_k1 got %0d %0d want 192 191",
               log_re[l1 + 2], log_im[l1 + 2]);
    end
    for (int k = 0; k < N; k++) begin
      int idx = l1 + 1 + k;
      int s = brev(k);
      checks++;
      if (log_en[idx] !== 1'b1 || log_re[idx] !== f_re[1][s] ||
          log_im[idx] !== f_im[1][s]) begin
        failures++;
        $display("FAIL gap k=%0d got %b %0d %0d want 1 %0d %0d", k,
                 log_en[idx], log_re[idx], log_im[idx], f_re[1][s], f_im[1][s]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int l0;
    int l1;
    fill_rand(0);
    fill_rand(1);
    send(0, 1'b0, l0);
    send(1, 1'b0, l1);
    idle(N + 4);
    for (int i = 0; i < 2 * N; i++) begin
      int idx = l0 + 1 + i;
      int f = i / N;
      int s = brev(i % N);
      checks++;
      if (log_en[idx] !== 1'b1 || log_re[idx] !== f_re[f][s] ||
          log_im[idx] !== f_im[f][s]) begin
        failures++;
        $display("FAIL b2b i=%0d got %b %0d %0d want 1 %0d %0d", i,
                 log_en[idx], log_re[idx], log_im[idx], f_re[f][s], f_im[f][s]);
      end
    end
    checks++;
    if (log_en[l0 + 1 + 2 * N] !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end got en=%b want 0", log_en[l0 + 1 + 2 * N]);
    end
  endtask

  task automatic test_toggle();
    int last;
    fill_ramp(0, 0, 127);
    send(0, 1'b1, last);
    idle(N + 4);
    checks++;
    if (log_en[last] !== 1'b0) begin
      failures++;
      $display("FAIL toggle_early got en=%b want 0", log_en[last]);
    end
    for (int k = 0; k < N; k++) begin
      int idx = last + 1 + k;
      int s = brev(k);
      checks++;
      if (log_en[idx] !== 1'b1 || log_re[idx] !== W'(s) ||
          log_im[idx] !== W'(127 - s)) begin
        failures++;
        $display("FAIL toggle k=%0d got %b %0d %0d want 1 %0d %0d", k,
                 log_en[idx], log_re[idx], log_im[idx], s, 127 - s);
      end
    end
  endtask

  task automatic test_partial();
    int t0;
    int cnt;
    int last;
    fill_rand(0);
    t0 = e;
    for (int i = 0; i < N - 1; i++) begin
      step(1'b1, f_re[0][i], f_im[0][i]);
    end
    idle(300);
    cnt = 0;
    for (int i = t0 + 1; i <= e; i++) begin
      if (log_en[i] !== 1'b0) cnt++;
    end
    checks++;
    if (cnt != 0) begin
      failures++;
      $display("FAIL partial_quiet got %0d en cycles want 0", cnt);
    end
    step(1'b1, f_re[0][N-1], f_im[0][N-1]);
    last = e;
    idle(N + 4);
    for (int k = 0; k < N; k++) begin
      int idx = last + 1 + k;
      int s = brev(k);
      checks++;
      if (log_en[idx] !== 1'b1 || log_re[idx] !== f_re[0][s] ||
          log_im[idx] !== f_im[0][s]) begin
        failures++;
        $display("FAIL partial_done k=%0d got %b %0d %0d want 1 %0d %0d", k,
                 log_en[idx], log_re[idx], log_im[idx], f_re[0][s], f_im[0][s]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int t0;
    int cnt;
    int last;
    for (int i = 0; i < 50; i++) begin
      step(1'b1, W'($urandom), W'($urandom));
    end
    reset = 1'b0;
    #1;
    checks++;
    if (do_en !== 1'b0 || do_re !== '0 || do_im !== '0) begin
      failures++;
      $display("FAIL rst_mid_out got %b %0d %0d want 0 0 0", do_en, do_re, do_im);
    end
    idle(3);
    reset = 1'b1;
    t0 = e;
    fill_rand(0);
    send(0, 1'b0, last);
    idle(N + 4);
    cnt = 0;
    for (int i = t0 + 1; i <= e; i++) begin
      if (log_en[i] === 1'b1) cnt++;
    end
    checks++;
    if (cnt != N) begin
      failures++;
      $display("FAIL rst_mid_count got %0d want %0d", cnt, N);
    end
    for (int k = 0; k < N; k++) begin
      int idx = last + 1 + k;
      int s = brev(k);
      checks++;
      if (log_en[idx] !== 1'b1 || log_re[idx] !== f_re[0][s] ||
          log_im[idx] !== f_im[0][s]) begin
        failures++;
        $display("FAIL rst_mid k=%0d got %b %0d %0d want 1 %0d %0d", k,
                 log_en[idx], log_re[idx], log_im[idx], f_re[0][s], f_im[0][s]);
      end
    end
    fill_rand(1);
    send(1, 1'b0, last);
    idle(40);
    checks++;
    if (do_en !== 1'b1) begin
      failures++;
      $display("FAIL rst_run_active got en=%b want 1", do_en);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (do_en !== 1'b0 || do_re !== '0 || do_im !== '0) begin
      failures++;
      $display("FAIL rst_run_abort got %b %0d %0d want 0 0 0", do_en, do_re, do_im);
    end
    idle(2);
    reset = 1'b1;
    t0 = e;
    idle(N + 5);
    cnt = 0;
    for (int i = t0 + 1; i <= e; i++) begin
      if (log_en[i] !== 1'b0) cnt++;
    end
    checks++;
    if (cnt != 0) begin
      failures++;
      $display("FAIL rst_run_after got %0d en cycles want 0", cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_gap_frames();
    test_back_to_back();
    test_toggle();
    test_partial();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
